// File: rtl/tpu_pkg.sv
// Shared types and defaults for the TPU command engine.
// State encoding, default geometry and the element index range check.
package tpu_pkg;

   localparam int TPU_DIM    = 4;
   localparam int TPU_DATA_W = 32;
   localparam int TPU_IDX_W  = 5;

   typedef enum logic [1:0] {
      IDLE,
      COMPUTE,
      DONE
   } tpu_state_t;

   // True when both indices address an element of a dim x dim matrix.
   function automatic logic idx_in_range(
      input int unsigned row,
      input int unsigned col,
      input int unsigned dim
   );
      return (row < dim) && (col < dim);
   endfunction

endpackage

// File: rtl/tpu_cmd_engine_if.sv
// Command/response bundle between ID/EX decode and the TPU engine.
// master = decode side, slave = engine side.
interface tpu_cmd_engine_if #(
   parameter int DATA_W = 32,
   parameter int IDX_W  = 5
);

   logic              start_i;
   logic              wr_en_a_i;
   logic              wr_en_b_i;
   logic              wr_en_c_i;
   logic [IDX_W-1:0]  row_i;
   logic [IDX_W-1:0]  col_i;
   logic [DATA_W-1:0] wr_data_i;
   logic              rd_en_i;
   logic [DATA_W-1:0] rd_data_o;
   logic              busy_o;
   logic              done_o;
   logic              stall_o;

   modport master (
      output start_i, wr_en_a_i, wr_en_b_i, wr_en_c_i,
      output row_i, col_i, wr_data_i, rd_en_i,
      input  rd_data_o, busy_o, done_o, stall_o
   );

   modport slave (
      input  start_i, wr_en_a_i, wr_en_b_i, wr_en_c_i,
      input  row_i, col_i, wr_data_i, rd_en_i,
      output rd_data_o, busy_o, done_o, stall_o
   );

endinterface

// File: rtl/tpu_mac.sv
// Combinational multiply-accumulate: sum_o = acc_i + a_i * b_i.
// Define TPU_SAT_ACC_EN for a signed saturating accumulate.
module tpu_mac #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] acc_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] sum_o
);

`ifdef TPU_SAT_ACC_EN
   localparam int PW = 2 * DATA_W;

   localparam logic signed [PW:0] MAX_V =
      {{(PW - DATA_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
   localparam logic signed [PW:0] MIN_V =
      {{(PW - DATA_W + 2){1'b1}}, {(DATA_W - 1){1'b0}}};

   logic signed [PW-1:0] prod_w;
   logic signed [PW:0]   sum_w;

   // Full-width signed product, widened add, then clamp to DATA_W range.
   always_comb begin
      prod_w = $signed({{DATA_W{a_i[DATA_W-1]}}, a_i})
             * $signed({{DATA_W{b_i[DATA_W-1]}}, b_i});
      sum_w  = $signed({{(DATA_W + 1){acc_i[DATA_W-1]}}, acc_i})
             + $signed({prod_w[PW-1], prod_w});
      if (sum_w > MAX_V) begin
         sum_o = MAX_V[DATA_W-1:0];
      end else if (sum_w < MIN_V) begin
         sum_o = MIN_V[DATA_W-1:0];
      end else begin
         sum_o = sum_w[DATA_W-1:0];
      end
   end
`else
   logic [DATA_W-1:0] prod_t;

   // Truncated product and wrapping sum.
   always_comb begin
      prod_t = a_i * b_i;
      sum_o  = acc_i + prod_t;
   end
`endif

endmodule

// File: rtl/tpu_cmd_engine.sv
// Execute-side TPU responder: element writes to A/B/C, C += A*B on start.
// Optional saturating accumulate when TPU_SAT_ACC_EN is defined.
module tpu_cmd_engine
   import tpu_pkg::*;
#(
   parameter int DIM    = TPU_DIM,
   parameter int DATA_W = TPU_DATA_W,
   parameter int IDX_W  = TPU_IDX_W
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   tpu_cmd_engine_if.slave   cmd
);

   localparam int AW = (DIM > 1) ? $clog2(DIM) : 1;
   localparam logic [AW-1:0] LAST = AW'(DIM - 1);

   tpu_state_t state_q;
   logic [AW-1:0] i_q, j_q, k_q;
   logic busy_q, done_q;

   logic [DATA_W-1:0] a_q [DIM][DIM];
   logic [DATA_W-1:0] b_q [DIM][DIM];
   logic [DATA_W-1:0] c_q [DIM][DIM];

   logic [AW-1:0]     row_s, col_s;
   logic              in_rng;
   logic              any_cmd;
   logic [DATA_W-1:0] mac_acc, mac_a, mac_b, mac_sum;

   // Element address decode and hazard stall.
   always_comb begin
      row_s   = cmd.row_i[AW-1:0];
      col_s   = cmd.col_i[AW-1:0];
      in_rng  = idx_in_range(32'(cmd.row_i), 32'(cmd.col_i), DIM);
      any_cmd = cmd.start_i | cmd.wr_en_a_i | cmd.wr_en_b_i
              | cmd.wr_en_c_i | cmd.rd_en_i;
   end

   assign cmd.stall_o   = busy_q & any_cmd;
   assign cmd.busy_o    = busy_q;
   assign cmd.done_o    = done_q;
   assign cmd.rd_data_o = in_rng ? c_q[row_s][col_s] : '0;

   // Operands for the current (i, j, k) step.
   always_comb begin
      mac_acc = c_q[i_q][j_q];
      mac_a   = a_q[i_q][k_q];
      mac_b   = b_q[k_q][j_q];
   end

   tpu_mac #(
      .DATA_W (DATA_W)
   ) u_mac (
      .acc_i (mac_acc),
      .a_i   (mac_a),
      .b_i   (mac_b),
      .sum_o (mac_sum)
   );

   // Sequencer: walks k fastest, then j, then i; flags busy/done.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (cmd.start_i) begin
                  state_q <= COMPUTE;
                  i_q     <= '0;
                  j_q     <= '0;
                  k_q     <= '0;
                  busy_q  <= 1'b1;
               end
            end
            COMPUTE: begin
               if (k_q == LAST) begin
                  k_q <= '0;
                  if (j_q == LAST) begin
                     j_q <= '0;
                     if (i_q == LAST) begin
                        i_q     <= '0;
                        state_q <= DONE;
                        done_q  <= 1'b1;
                     end else begin
                        i_q <= i_q + 1'b1;
                     end
                  end else begin
                     j_q <= j_q + 1'b1;
                  end
               end else begin
                  k_q <= k_q + 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // Matrix storage: MAC writeback while computing, element writes when idle.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
               a_q[r][c] <= '0;
               b_q[r][c] <= '0;
               c_q[r][c] <= '0;
            end
         end
      end else if (state_q == COMPUTE) begin
         c_q[i_q][j_q] <= mac_sum;
      end else if (state_q == IDLE && in_rng) begin
         if (cmd.wr_en_a_i) a_q[row_s][col_s] <= cmd.wr_data_i;
         if (cmd.wr_en_b_i) b_q[row_s][col_s] <= cmd.wr_data_i;
         if (cmd.wr_en_c_i) c_q[row_s][col_s] <= cmd.wr_data_i;
      end
   end

endmodule

// File: doc/tpu_cmd_engine.md
Name: tpu_cmd_engine

Overview:
- Execute-side responder for the TPU command fields that decode registers into ID/EX: start, write-enable A/B/C, row, col and operand data.
- Holds matrices A, B and C. Writes individual elements, runs C += A*B sequentially on start, and serves element reads of C for writeback.
- Back-pressures the pipeline through stall_o while a computation is in flight.

Parameters:
- DIM, 4: matrix dimension. Square DIMxDIM matrices; legal values 2..16.
- DATA_W, 32: element width, two's-complement.
- IDX_W, 5: row/col index width, matching the decode row/col fields.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- start_i  in  1  launch C += A*B
- wr_en_a_i  in  1  write A[row_i][col_i]
- wr_en_b_i  in  1  write B[row_i][col_i]
- wr_en_c_i  in  1  write C[row_i][col_i]
- row_i  in  IDX_W  element row
- col_i  in  IDX_W  element column
- wr_data_i  in  DATA_W  element write data
- rd_en_i  in  1  read request for C[row_i][col_i]
- rd_data_o  out  DATA_W  C element, combinational from row_i/col_i
- busy_o  out  1  computation in progress
- done_o  out  1  one-cycle pulse when computation completes
- stall_o  out  1  pipeline stall request to the hazard unit

Behaviour:
- Reset (async): state IDLE; counters i, j, k = 0; A, B, C all zero; busy_o=0, done_o=0, stall_o=0.
- FSM states: IDLE, COMPUTE, DONE.
  - IDLE -> COMPUTE on start_i.
  - COMPUTE -> DONE after the final MAC, at i=j=k=DIM-1.
  - DONE -> IDLE unconditionally, one cycle later.
- COMPUTE step: one MAC per cycle, C[i][j] <= C[i][j] + A[i][k]*B[k][j].
  - Product truncated to DATA_W; sum wraps modulo 2^DATA_W.
  - Loop order: k innermost, then j, then i.
- Latency: DIM^3 COMPUTE cycles plus 1 DONE cycle.
  - busy_o=1 in COMPUTE and DONE.
  - done_o=1 only in DONE.
  - First cycle with busy_o=0 is DIM^3+1 cycles after the start edge.
- Writes in IDLE: committed at the clock edge. Any combination of wr_en_a/b/c may be set together; each enabled matrix takes wr_data_i.
- start_i together with writes in IDLE: writes commit on the same edge; compute begins next cycle using the updated values.
- stall_o = busy_o & (start_i | wr_en_a_i | wr_en_b_i | wr_en_c_i | rd_en_i). This is combinational.
  - Stalled commands are ignored; decode holds and re-presents them.
  - start_i during busy never restarts or queues a computation.
- Index out of range (row_i>=DIM or col_i>=DIM): write ignored; rd_data_o=0; no stall from the range check itself.
- rd_data_o is valid combinationally in IDLE. While busy it shows the current C storage, but consumers must honour stall_o.
- Reset mid-COMPUTE: immediate return to IDLE, matrices cleared, no done_o pulse.

Optional Feature:
- Macro TPU_SAT_ACC_EN.
- Defined: each accumulate saturates to the signed DATA_W range, [-2^(DATA_W-1), 2^(DATA_W-1)-1]. The product is formed at 2*DATA_W bits before the add.
- Undefined: truncating, wrapping arithmetic as described in Behaviour.
- Cycle timing is identical in both builds.

Decomposition:
- Package tpu_pkg:
  - FSM state enum tpu_state_t (IDLE, COMPUTE, DONE).
  - Default DIM, DATA_W, IDX_W constants.
  - Function for the in-range index check.
- Sub-module tpu_mac: combinational acc + a*b, with the TPU_SAT_ACC_EN saturation path. Instantiated once inside tpu_cmd_engine.

Test Plan:
1. DIM=4. Write A=identity, B[r][c]=r*4+c, C=0, then start.
   - busy_o high for 65 cycles, done_o pulses on cycle 65.
   - Afterwards every C[r][c] reads r*4+c.
2. During COMPUTE, assert wr_en_a_i with row=0, col=0, data=7.
   - stall_o=1 that cycle; A[0][0] unchanged.
   - Result identical to scenario 1.
3. wr_en_b_i with row_i=5, col_i=1, data=9 (out of range).
   - No write, stall_o=0.
   - rd_en_i at row 5 returns 0.
4. Start, then deassert rst_n_i at COMPUTE cycle 20.
   - busy_o=0 immediately, no done_o pulse.
   - All C reads return 0.
5. Same edge: start_i with wr_en_c_i at C[1][1]=100, A=B=identity.
   - After done_o, C[1][1]=101.
6. TPU_SAT_ACC_EN build: A[0][0]=B[0][0]=0x10000, others 0, C[0][0]=0x7FFFFFF0.
   - Result C[0][0]=0x7FFFFFFF.
   - Without the macro, C[0][0]=0x7FFFFFF0 (product truncates to 0).
